branch_resolve_unit: RTL

//  Consumer end of the ALU flag interface. Holds the architectural N/Z/V flag register and updates it from ALU results

---
 rtl/cpu_br_pkg.sv | 47 ++++
 rtl/branch_cond_eval.sv | 26 ++
 rtl/branch_resolve_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/cpu_br_pkg.sv
// Shared ALU opcode / branch condition encodings, branch FSM states and the per-opcode flag update mask.
package cpu_br_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_SR  = 3'b110;
  localparam logic [2:0] OP_ROT = 3'b111;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_AL = 3'b111;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } br_state_e;

  // Bits set in the result are the flags that opcode is allowed to overwrite.
  function automatic flags_t flag_mask(input logic [2:0] op);
    flags_t m;
    m = '0;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT: m = '{n: 1'b1, z: 1'b1, v: 1'b0};
      OP_ADD:                        m = '{n: 1'b1, z: 1'b1, v: 1'b1};
      OP_LSL, OP_SR:                 m = '{n: 1'b0, z: 1'b1, v: 1'b0};
      default:                       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: {N,Z,V} + 3-bit condition -> taken.
// Zero latency, no flow control.
module branch_cond_eval
  import cpu_br_pkg::*;
(
  input  flags_t     flags,
  input  logic [2:0] cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NE: taken = ~flags.z;
      COND_EQ: taken = flags.z;
      COND_GT: taken = ~flags.z & ~flags.n;
      COND_LT: taken = flags.n;
      COND_GE: taken = ~flags.n | flags.z;
      COND_LE: taken = flags.n | flags.z;
      COND_OV: taken = flags.v;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Flag register, branch resolve and redirect/flush sequencing; redirect at t+1, flush FLUSH_CYCLES after handshake.
// br_ready drops while a redirect waits on fetch or a flush runs; BRANCH_STATS_EN adds accepted-branch counters.
module branch_resolve_unit
  import cpu_br_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int OFF_W        = 9,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_flag_we,
  input  logic [2:0]       alu_op,
  input  logic             alu_N,
  input  logic             alu_Z,
  input  logic             alu_V,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [OFF_W-1:0] br_offset,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
`ifdef BRANCH_STATS_EN
  input  logic             stat_clr,
  output logic [15:0]      stat_taken,
  output logic [15:0]      stat_not_taken,
`endif
  output logic [2:0]       flags
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  br_state_e        state, state_nxt;
  flags_t           flags_q, flags_eff, mask, alu_flags;
  logic [CNT_W-1:0] flush_cnt;
  logic [PC_W-1:0]  target;
  logic             taken, accept;

  // Forwarded flags: a same-cycle ALU write is visible to the branch being evaluated.
  always_comb begin
    mask      = flag_mask(alu_op);
    alu_flags = '{n: alu_N, z: alu_Z, v: alu_V};
    flags_eff = flags_q;
    if (alu_flag_we)
      flags_eff = (alu_flags & mask) | (flags_q & ~mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_eff;
  end

  assign flags = flags_q;

  branch_cond_eval u_cond_eval (
    .flags (flags_eff),
    .cond  (br_cond),
    .taken (taken)
  );

  assign target = br_pc + PC_W'(1) + {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};
  assign accept = br_valid & br_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && taken)   state_nxt = HOLD;
      HOLD:    if (redirect_ready)    state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == '0)   state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    br_ready       = (state == IDLE);
    redirect_valid = (state == HOLD);
    flush          = (state == FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc <= '0;
      flush_cnt   <= '0;
    end else begin
      if (state == IDLE && accept && taken)
        redirect_pc <= target;
      if (state == HOLD && redirect_ready)
        flush_cnt <= CNT_W'(FLUSH_CYCLES - 1);
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (stat_clr) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (accept) begin
      if (taken && stat_taken != 16'hFFFF)
        stat_taken <= stat_taken + 16'd1;
      else if (!taken && stat_not_taken != 16'hFFFF)
        stat_not_taken <= stat_not_taken + 16'd1;
    end
  end
`endif

endmodule
